mat_mult_arbiter: RTL and testbench
===================================

Name: mat_mult_arbiter

Overview:
Shares one 4x4 signed 16-bit matrix multiplier among NUM_REQ requesters (predict, update and gain stages of the Kalman filter). Each requester presents a pair of packed 256-bit operands. The block grants requesters round-robin, registers the operands onto the multiplier inputs, and waits MULT_LAT cycles. It then captures the product and returns it to the granted requester over a valid/ready response channel. The multiplier is instantiated outside this block, alongside it.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
MULT_LAT, 1, cycles from mm_a/mm_b update to valid mm_res (>=1)
ID_W, 2, width of grant_id; must be >= clog2(NUM_REQ), minimum 1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  NUM_REQ  per-requester operand valid
req_ready  out  NUM_REQ  per-requester operand accept (one-hot or zero)
req_a  in  NUM_REQ*256  operand A per requester; requester n at [n*256 +: 256]
req_b  in  NUM_REQ*256  operand B per requester, same packing
resp_valid  out  NUM_REQ  per-requester result valid (one-hot or zero)
resp_ready  in  NUM_REQ  per-requester result accept
resp_data  out  256  captured product, shared by all requesters
mm_a  out  256  registered operand A to multiplier
mm_b  out  256  registered operand B to multiplier
mm_res  in  256  multiplier product
grant_id  out  ID_W  index of the current/last granted requester
busy  out  1  high in WAIT and RESP
ops_done  out  16  count of completed response handshakes

Behaviour:
- Matrix packing: row-major, 16-bit two's-complement elements, [0][0] at bits 255:240, [3][3] at bits 15:0. The block never modifies data; it passes operands and the product through bit-exact.
- FSM states: IDLE, WAIT, RESP.
- Reset values: state=IDLE, mm_a=0, mm_b=0, resp_data=0, resp_valid=0, req_ready=0, busy=0, ops_done=0, grant_id=0, last_grant=NUM_REQ-1 (requester 0 wins first).
- IDLE, request selection:
  - Combinationally select the first asserted req_valid, searching from last_grant+1 upward with wrap to 0.
  - Drive req_ready high for that requester only; the handshake completes that cycle.
  - On the edge: mm_a/mm_b <= selected operands, grant_id <= selection, lat_cnt <= MULT_LAT-1, state -> WAIT.
  - If no req_valid is asserted, stay in IDLE and hold all registers.
- WAIT:
  - req_ready=0 for all requesters.
  - If lat_cnt==0: resp_data <= mm_res and state -> RESP. Otherwise decrement lat_cnt.
- RESP:
  - resp_valid[grant_id]=1; resp_data and mm_a/mm_b held stable.
  - When resp_ready[grant_id]=1: ops_done <= ops_done+1 (wraps 0xFFFF->0), last_grant <= grant_id, state -> IDLE.
  - resp_ready on any other index is ignored.
- Timing:
  - resp_valid rises MULT_LAT+1 cycles after the request handshake cycle.
  - No new grant is issued in the response-handshake cycle. Minimum issue interval is MULT_LAT+2 cycles.
- Requester rules:
  - A requester may drop req_valid before being granted; it simply loses arbitration.
  - req_a/req_b are sampled only in the handshake cycle.
- Reset mid-operation: any in-flight operation is discarded with no response and all outputs return to reset values. The next grant goes to the lowest-indexed valid requester.
- busy = (state != IDLE).

Test Plan:
1. Assert rst for 2 cycles with arbitrary inputs -> all outputs 0, req_ready=0; first request from requester 2 alone is granted and grant_id=2.
2. Requester 0: A=identity (diag 16'h0001), B=16 elements 16'h0001..16'h0010, MULT_LAT=1, model mm_res=A*B -> req_ready[0] pulses 1 cycle; resp_valid[0] rises 2 cycles later; resp_data==B; ops_done=1.
3. All three req_valid held high, resp_ready tied high -> grant order 0,1,2,0,1; each issue 3 cycles apart; resp_valid never on two bits at once.
4. A=all 16'hFFFF, B=all 16'h0002 -> resp_data = all 16'hFFF8. Then hold resp_ready low 5 cycles -> resp_valid and resp_data stable, no req_ready asserted meanwhile.
5. MULT_LAT=3: mm_res changes each cycle -> resp_data equals the mm_res value from exactly 3 cycles after the mm_a update.
6. Assert rst during WAIT with requester 1 granted -> no resp_valid. After release with requesters 1 and 2 valid, requester 1 is granted first (lowest index after the reset of last_grant).

Source files
------------

// File: rtl/mat_mult_arbiter.sv
// Round-robin share of one external 4x4 int16 matrix multiplier; result returns MULT_LAT+1 cycles after grant.
// A stalled response (resp_ready low) holds the result and blocks all new grants until it is accepted.
module mat_mult_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int MULT_LAT = 1,
  parameter int ID_W     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*256-1:0] req_a,
  input  logic [NUM_REQ*256-1:0] req_b,
  output logic [NUM_REQ-1:0]     resp_valid,
  input  logic [NUM_REQ-1:0]     resp_ready,
  output logic [255:0]           resp_data,
  output logic [255:0]           mm_a,
  output logic [255:0]           mm_b,
  input  logic [255:0]           mm_res,
  output logic [ID_W-1:0]        grant_id,
  output logic                   busy,
  output logic [15:0]            ops_done
);

  localparam int LAT_W = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state;
  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   sel_id;
  logic              sel_vld;
  logic [LAT_W-1:0]  lat_cnt;
  logic [255:0]      sel_a;
  logic [255:0]      sel_b;
  logic [NUM_REQ-1:0] grant_oh;
  logic              resp_hs;

  // Two-pass priority search: indices above last_grant first, then wrap to 0.
  always_comb begin
    sel_vld = 1'b0;
    sel_id  = '0;
    for (int n = 0; n < NUM_REQ; n++) begin
      if (!sel_vld && req_valid[n] && (ID_W'(n) > last_grant)) begin
        sel_vld = 1'b1;
        sel_id  = ID_W'(n);
      end
    end
    for (int n = 0; n < NUM_REQ; n++) begin
      if (!sel_vld && req_valid[n] && (ID_W'(n) <= last_grant)) begin
        sel_vld = 1'b1;
        sel_id  = ID_W'(n);
      end
    end
  end

  always_comb begin
    sel_a     = '0;
    sel_b     = '0;
    req_ready = '0;
    grant_oh  = '0;
    for (int n = 0; n < NUM_REQ; n++) begin
      if (ID_W'(n) == sel_id) begin
        sel_a = req_a[n*256 +: 256];
        sel_b = req_b[n*256 +: 256];
      end
      req_ready[n] = !rst && (state == IDLE) && sel_vld && (ID_W'(n) == sel_id);
      grant_oh[n]  = (ID_W'(n) == grant_id);
    end
  end

  // resp_valid is one-hot at grant_id, so this only sees the granted requester's ready.
  assign resp_hs = |(resp_valid & resp_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mm_a       <= '0;
      mm_b       <= '0;
      resp_data  <= '0;
      resp_valid <= '0;
      busy       <= 1'b0;
      ops_done   <= '0;
      grant_id   <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
      lat_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_vld) begin
            mm_a     <= sel_a;
            mm_b     <= sel_b;
            grant_id <= sel_id;
            lat_cnt  <= LAT_W'(MULT_LAT - 1);
            busy     <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt == '0) begin
            resp_data  <= mm_res;
            resp_valid <= grant_oh;
            state      <= RESP;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        RESP: begin
          if (resp_hs) begin
            resp_valid <= '0;
            ops_done   <= ops_done + 16'd1;
            last_grant <= grant_id;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mat_mult_arbiter.sv
// Directed bench for mat_mult_arbiter: one instance at MULT_LAT=1 with a combinational
// multiplier model, one at MULT_LAT=3 fed a per-cycle changing product.
module tb_mat_mult_arbiter;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [15:0] cyc = 16'd0;
  always @(posedge clk) cyc <= cyc + 16'd1;

  logic [N-1:0]     req_valid, req_ready, resp_valid, resp_ready;
  logic [N*256-1:0] req_a, req_b;
  logic [255:0]     resp_data, mm_a, mm_b, mm_res;
  logic [1:0]       grant_id;
  logic             busy;
  logic [15:0]      ops_done;

  logic [N-1:0]     req_valid3, req_ready3, resp_valid3, resp_ready3;
  logic [N*256-1:0] req_a3, req_b3;
  logic [255:0]     resp_data3, mm_a3, mm_b3, mm_res3;
  logic [1:0]       grant_id3;
  logic             busy3;
  logic [15:0]      ops_done3;

  int checks = 0;
  int errors = 0;
  int exp_ops = 0;

  function automatic logic [255:0] matmul(input logic [255:0] a, input logic [255:0] b);
    logic [255:0] r;
    logic signed [15:0] ea, eb;
    logic signed [31:0] p;
    logic [15:0] acc;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        acc = 16'd0;
        for (int k = 0; k < 4; k++) begin
          ea  = a[255 - 16*(4*i+k) -: 16];
          eb  = b[255 - 16*(4*k+j) -: 16];
          p   = ea * eb;
          acc = acc + p[15:0];
        end
        r[255 - 16*(4*i+j) -: 16] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [255:0] mk_mat(input int base, input int step);
    logic [255:0] r;
    for (int e = 0; e < 16; e++) r[255 - 16*e -: 16] = 16'(base + step*e);
    return r;
  endfunction

  assign mm_res  = matmul(mm_a, mm_b);
  assign mm_res3 = {16{cyc}};

  mat_mult_arbiter #(.NUM_REQ(N), .MULT_LAT(1), .ID_W(2)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .mm_a(mm_a), .mm_b(mm_b), .mm_res(mm_res),
    .grant_id(grant_id), .busy(busy), .ops_done(ops_done)
  );

  mat_mult_arbiter #(.NUM_REQ(N), .MULT_LAT(3), .ID_W(2)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_a(req_a3), .req_b(req_b3), .resp_valid(resp_valid3), .resp_ready(resp_ready3),
    .resp_data(resp_data3), .mm_a(mm_a3), .mm_b(mm_b3), .mm_res(mm_res3),
    .grant_id(grant_id3), .busy(busy3), .ops_done(ops_done3)
  );

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic test_reset;
    logic [255:0] a2;
    rst = 1'b1;
    req_valid = 3'b111;
    for (int w = 0; w < N*256/32; w++) begin
      req_a[w*32 +: 32] = $urandom;
      req_b[w*32 +: 32] = $urandom;
    end
    resp_ready = 3'b111;
    repeat (2) tick;
    #1;
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL rst_req_ready got %b exp 000", req_ready); end
    checks++; if (resp_valid !== 3'b000) begin errors++; $display("FAIL rst_resp_valid got %b exp 000", resp_valid); end
    checks++; if (busy !== 1'b0 || grant_id !== 2'd0 || ops_done !== 16'd0) begin
      errors++; $display("FAIL rst_ctrl got busy=%b id=%0d ops=%0d exp 0/0/0", busy, grant_id, ops_done); end
    checks++; if (mm_a !== '0 || mm_b !== '0 || resp_data !== '0) begin
      errors++; $display("FAIL rst_data got mm_a=%h resp=%h exp 0", mm_a, resp_data); end
    rst = 1'b0;
    a2 = mk_mat(7, 3);
    req_a[2*256 +: 256] = a2;
    req_valid = 3'b100;
    #1;
    checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL first_grant_ready got %b exp 100", req_ready); end
    tick;
    req_valid = 3'b000;
    #1;
    checks++; if (grant_id !== 2'd2 || busy !== 1'b1) begin
      errors++; $display("FAIL first_grant_id got id=%0d busy=%b exp 2/1", grant_id, busy); end
    checks++; if (mm_a !== a2) begin errors++; $display("FAIL first_grant_mm_a got %h exp %h", mm_a, a2); end
    tick; #1;
    checks++; if (resp_valid !== 3'b100) begin errors++; $display("FAIL first_resp_valid got %b exp 100", resp_valid); end
    tick; #1;
    exp_ops = 1;
    checks++; if (ops_done !== 16'(exp_ops) || busy !== 1'b0) begin
      errors++; $display("FAIL first_done got ops=%0d busy=%b exp %0d/0", ops_done, busy, exp_ops); end
  endtask

  task automatic test_single;
    logic [255:0] ident, bseq, expd;
    ident = '0;
    for (int d = 0; d < 4; d++) ident[255 - 16*(5*d) -: 16] = 16'h0001;
    bseq = mk_mat(1, 1);
    expd = matmul(ident, bseq);
    req_a[0 +: 256] = ident;
    req_b[0 +: 256] = bseq;
    resp_ready = 3'b000;
    req_valid = 3'b001;
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL single_ready got %b exp 001", req_ready); end
    tick;
    req_valid = 3'b000;
    #1;
    checks++; if (req_ready !== 3'b000 || resp_valid !== 3'b000) begin
      errors++; $display("FAIL single_wait got rdy=%b vld=%b exp 000/000", req_ready, resp_valid); end
    tick; #1;
    checks++; if (resp_valid !== 3'b001) begin errors++; $display("FAIL single_resp_valid got %b exp 001", resp_valid); end
    checks++; if (resp_data !== bseq || resp_data !== expd) begin
      errors++; $display("FAIL single_resp_data got %h exp %h", resp_data, bseq); end
    resp_ready = 3'b001;
    tick; #1;
    exp_ops++;
    checks++; if (resp_valid !== 3'b000 || ops_done !== 16'(exp_ops)) begin
      errors++; $display("FAIL single_done got vld=%b ops=%0d exp 000/%0d", resp_valid, ops_done, exp_ops); end
  endtask

  task automatic test_round_robin;
    logic [255:0] op_a [N];
    logic [255:0] op_b [N];
    logic [255:0] expd;
    int g_id [8];
    int g_cyc [8];
    int ng;
    int exp_order [5];
    int idx;
    exp_order = '{0, 1, 2, 0, 1};
    ng = 0;
    for (int n = 0; n < N; n++) begin
      op_a[n] = mk_mat(n + 2, n + 1);
      op_b[n] = mk_mat(-3 * n, 2);
      req_a[n*256 +: 256] = op_a[n];
      req_b[n*256 +: 256] = op_b[n];
    end
    rst = 1'b1;
    req_valid = 3'b000;
    resp_ready = 3'b111;
    repeat (2) tick;
    rst = 1'b0;
    exp_ops = 0;
    req_valid = 3'b111;
    for (int c = 0; c < 14; c++) begin
      if (c == 13) req_valid = 3'b000;
      #1;
      checks++; if (!$onehot0(req_ready) || !$onehot0(resp_valid)) begin
        errors++; $display("FAIL rr_onehot cycle %0d got rdy=%b vld=%b", c, req_ready, resp_valid); end
      if (req_ready != 3'b000 && ng < 8) begin
        idx = 0;
        for (int n = 0; n < N; n++) if (req_ready[n]) idx = n;
        g_id[ng] = idx;
        g_cyc[ng] = c;
        ng++;
      end
      if (resp_valid != 3'b000 && ng > 0) begin
        idx = g_id[ng-1];
        expd = matmul(op_a[idx], op_b[idx]);
        checks++; if (resp_valid !== 3'(1 << idx) || resp_data !== expd) begin
          errors++; $display("FAIL rr_resp cycle %0d got vld=%b data=%h exp req %0d data=%h", c, resp_valid, resp_data, idx, expd); end
      end
      tick;
    end
    checks++; if (ng !== 5) begin errors++; $display("FAIL rr_grant_count got %0d exp 5", ng); end
    for (int i = 0; i < 5 && i < ng; i++) begin
      checks++; if (g_id[i] !== exp_order[i]) begin
        errors++; $display("FAIL rr_order grant %0d got %0d exp %0d", i, g_id[i], exp_order[i]); end
      if (i > 0) begin
        checks++; if (g_cyc[i] - g_cyc[i-1] !== 3) begin
          errors++; $display("FAIL rr_interval grant %0d got %0d exp 3", i, g_cyc[i] - g_cyc[i-1]); end
      end
    end
    #1;
    checks++; if (resp_valid !== 3'b010) begin errors++; $display("FAIL rr_last_resp got %b exp 010", resp_valid); end
    tick; #1;
    exp_ops = 5;
    checks++; if (ops_done !== 16'(exp_ops)) begin errors++; $display("FAIL rr_ops got %0d exp %0d", ops_done, exp_ops); end
  endtask

  task automatic test_backpressure;
    logic [255:0] fff8;
    fff8 = {16{16'hFFF8}};
    req_a[2*256 +: 256] = {16{16'hFFFF}};
    req_b[2*256 +: 256] = {16{16'h0002}};
    resp_ready = 3'b000;
    req_valid = 3'b100;
    #1;
    checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL bp_ready got %b exp 100", req_ready); end
    tick;
    req_valid = 3'b011;
    #1;
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL bp_wait_ready got %b exp 000", req_ready); end
    tick; #1;
    checks++; if (resp_valid !== 3'b100 || resp_data !== fff8) begin
      errors++; $display("FAIL bp_resp got vld=%b data=%h exp 100/%h", resp_valid, resp_data, fff8); end
    for (int s = 0; s < 5; s++) begin
      tick; #1;
      checks++; if (resp_valid !== 3'b100 || resp_data !== fff8 || req_ready !== 3'b000) begin
        errors++; $display("FAIL bp_stall cycle %0d got vld=%b rdy=%b data=%h exp 100/000/%h", s, resp_valid, req_ready, resp_data, fff8); end
    end
    resp_ready = 3'b100;
    tick; #1;
    exp_ops++;
    checks++; if (resp_valid !== 3'b000 || ops_done !== 16'(exp_ops) || req_ready !== 3'b001) begin
      errors++; $display("FAIL bp_release got vld=%b ops=%0d rdy=%b exp 000/%0d/001", resp_valid, ops_done, req_ready, exp_ops); end
    req_valid = 3'b000;
    resp_ready = 3'b111;
  endtask

  task automatic test_latency3;
    logic [255:0] a0;
    logic [15:0] c0;
    a0 = mk_mat(100, 5);
    req_a3[0 +: 256] = a0;
    req_b3[0 +: 256] = mk_mat(9, 1);
    resp_ready3 = 3'b001;
    req_valid3 = 3'b001;
    #1;
    checks++; if (req_ready3 !== 3'b001) begin errors++; $display("FAIL lat3_ready got %b exp 001", req_ready3); end
    tick;
    req_valid3 = 3'b000;
    #1;
    c0 = cyc;
    checks++; if (mm_a3 !== a0) begin errors++; $display("FAIL lat3_mm_a got %h exp %h", mm_a3, a0); end
    for (int w = 0; w < 3; w++) begin
      if (w > 0) begin tick; #1; end
      checks++; if (resp_valid3 !== 3'b000) begin
        errors++; $display("FAIL lat3_early cycle %0d got %b exp 000", w, resp_valid3); end
    end
    tick; #1;
    checks++; if (resp_valid3 !== 3'b001 || resp_data3 !== {16{c0 + 16'd2}}) begin
      errors++; $display("FAIL lat3_resp got vld=%b data=%h exp 001/%h", resp_valid3, resp_data3, {16{c0 + 16'd2}}); end
    tick; #1;
    checks++; if (ops_done3 !== 16'd1 || busy3 !== 1'b0) begin
      errors++; $display("FAIL lat3_done got ops=%0d busy=%b exp 1/0", ops_done3, busy3); end
    resp_ready3 = 3'b000;
  endtask

  task automatic test_reset_mid;
    logic [255:0] a1;
    a1 = mk_mat(-40, 7);
    req_a[1*256 +: 256] = a1;
    resp_ready = 3'b111;
    req_valid = 3'b010;
    #1;
    checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL mid_ready got %b exp 010", req_ready); end
    tick;
    req_valid = 3'b110;
    #1;
    checks++; if (grant_id !== 2'd1 || busy !== 1'b1) begin
      errors++; $display("FAIL mid_grant got id=%0d busy=%b exp 1/1", grant_id, busy); end
    rst = 1'b1;
    #1;
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL mid_rst_ready got %b exp 000", req_ready); end
    tick; #1;
    checks++; if (resp_valid !== 3'b000 || busy !== 1'b0 || grant_id !== 2'd0 || mm_a !== '0 || ops_done !== 16'd0) begin
      errors++; $display("FAIL mid_rst_state got vld=%b busy=%b id=%0d ops=%0d exp 000/0/0/0", resp_valid, busy, grant_id, ops_done); end
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 3'b010 || resp_valid !== 3'b000) begin
      errors++; $display("FAIL mid_regrant got rdy=%b vld=%b exp 010/000", req_ready, resp_valid); end
    tick;
    req_valid = 3'b000;
    #1;
    checks++; if (grant_id !== 2'd1 || mm_a !== a1) begin
      errors++; $display("FAIL mid_regrant_id got id=%0d mm_a=%h exp 1/%h", grant_id, mm_a, a1); end
    tick; #1;
    checks++; if (resp_valid !== 3'b010) begin errors++; $display("FAIL mid_resp got %b exp 010", resp_valid); end
    tick; #1;
    checks++; if (ops_done !== 16'd1) begin errors++; $display("FAIL mid_ops got %0d exp 1", ops_done); end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_a = '0; req_b = '0; resp_ready = '0;
    req_valid3 = '0; req_a3 = '0; req_b3 = '0; resp_ready3 = '0;
    test_reset;
    test_single;
    test_round_robin;
    test_backpressure;
    test_latency3;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
